// File: rtl/dac_spi_multich.sv
// SPI master for DAC7554-class multichannel DACs: snapshots one word per channel
// and writes either one channel or all channels as {cmd, addr, data} frames.
module dac_spi_multich #(
    parameter int         CLK_DIV = 2,
    parameter int         DATA_W  = 12,
    parameter int         N_CH    = 4,
    parameter int         ADDR_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter logic [1:0] CMD_WR  = 2'b00,
    parameter logic [1:0] CMD_UPD = 2'b01,
    parameter int         GAP_CYC = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        ch_sel,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic                     busy,
    output logic                     done,
    output logic                     sync,
    output logic                     sclk,
    output logic                     sdi
);

    localparam int FRAME_W = 2 + ADDR_W + DATA_W;
    localparam int CNT_MAX = ((CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0]  DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [BIT_W-1:0]         bit_q;
    logic                     phase_hi_q;
    logic                     mode_q;
    logic [ADDR_W-1:0]        ch_q;
    logic [N_CH*DATA_W-1:0]   data_q;
    logic [FRAME_W-1:0]       shift_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     sync_q;
    logic                     sclk_q;
    logic                     sdi_q;

    logic                     start_ok;
    logic                     cur_last;
    logic                     load_mode_d;
    logic                     load_last_d;
    logic [ADDR_W-1:0]        load_ch_d;
    logic [N_CH*DATA_W-1:0]   load_data_d;
    logic [DATA_W-1:0]        load_word_data_d;
    logic [1:0]               load_cmd_d;
    logic [FRAME_W-1:0]       word_d;

    // The same word builder serves the first frame (from the live inputs) and
    // every following scan frame (from the snapshot).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        load_word_data_d = '0;
        start_ok    = start && (mode || (int'(ch_sel) < N_CH));
        cur_last    = !mode_q || (ch_q == LAST_CH);
        load_mode_d = (state_q == S_IDLE) ? mode : mode_q;
        load_data_d = (state_q == S_IDLE) ? data : data_q;
        if (state_q == S_IDLE) begin
            load_ch_d = mode ? '0 : ch_sel;
        end else begin
            load_ch_d = ch_q + ADDR_W'(1);
        end
        for (int c = 0; c < N_CH; c++) begin
            if (load_ch_d == ADDR_W'(c)) begin
                load_word_data_d = load_data_d[c*DATA_W +: DATA_W];
            end
        end
        load_last_d = !load_mode_d || (load_ch_d == LAST_CH);
        load_cmd_d  = load_last_d ? CMD_UPD : CMD_WR;
        word_d      = {load_cmd_d, load_ch_d, load_word_data_d};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            phase_hi_q <= 1'b0;
            mode_q     <= 1'b0;
            ch_q       <= '0;
            data_q     <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sync_q     <= 1'b1;
            sclk_q     <= 1'b1;
            sdi_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_ok) begin
                        mode_q  <= mode;
                        ch_q    <= load_ch_d;
                        data_q  <= data;
                        shift_q <= word_d;
                        sdi_q   <= word_d[FRAME_W-1];
                        sync_q  <= 1'b0;
                        sclk_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= DIV_LOAD;
                        state_q <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt_q == '0) begin
                        sclk_q     <= 1'b0;
                        cnt_q      <= DIV_LOAD;
                        bit_q      <= '0;
                        phase_hi_q <= 1'b0;
                        state_q    <= S_SHIFT;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                // sdi moves on the sclk rising edge, keeping it stable across the
                // falling edge where the DAC samples.
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!phase_hi_q) begin
                        sclk_q     <= 1'b1;
                        phase_hi_q <= 1'b1;
                        cnt_q      <= DIV_LOAD;
                        shift_q    <= shift_q << 1;
                        sdi_q      <= shift_q[FRAME_W-2];
                    end else if (bit_q == LAST_BIT) begin
                        sdi_q   <= 1'b0;
                        cnt_q   <= DIV_LOAD;
                        state_q <= S_HOLD;
                    end else begin
                        sclk_q     <= 1'b0;
                        phase_hi_q <= 1'b0;
                        bit_q      <= bit_q + BIT_W'(1);
                        cnt_q      <= DIV_LOAD;
                    end
                end

                S_HOLD: begin
                    if (cnt_q == '0) begin
                        sync_q  <= 1'b1;
                        cnt_q   <= GAP_LOAD;
                        done_q  <= cur_last && (GAP_CYC == 1);
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q  <= cnt_q - CNT_ONE;
                        done_q <= cur_last && (cnt_q == CNT_ONE);
                    end else begin
                        done_q <= 1'b0;
                        if (cur_last) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            ch_q    <= load_ch_d;
                            shift_q <= word_d;
                            sdi_q   <= word_d[FRAME_W-1];
                            sync_q  <= 1'b0;
                            cnt_q   <= DIV_LOAD;
                            state_q <= S_SETUP;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sync = sync_q;
    assign sclk = sclk_q;
    assign sdi  = sdi_q;

endmodule

// File: tb/tb_dac_spi_multich.sv
// Directed bench for dac_spi_multich: decodes frames from the DAC pins and
// checks framing, timing, command selection, snapshotting and reset abort.
module tb_dac_spi_multich;

    logic        clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_n;
    logic        start_r;
    logic        mode_r;
    logic [1:0]  ch_r;
    logic [63:0] data_r;
    int          sel;

    logic start0, start1, start2;
    logic busy0, done0, sync0, sclk0, sdi0;
    logic busy1, done1, sync1, sclk1, sdi1;
    logic busy2, done2, sync2, sclk2, sdi2;
    logic mon_busy, mon_done, mon_sync, mon_sclk, mon_sdi;

    assign start0 = start_r && (sel == 0);
    assign start1 = start_r && (sel == 1);
    assign start2 = start_r && (sel == 2);

    assign mon_busy = (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy0;
    assign mon_done = (sel == 1) ? done1 : (sel == 2) ? done2 : done0;
    assign mon_sync = (sel == 1) ? sync1 : (sel == 2) ? sync2 : sync0;
    assign mon_sclk = (sel == 1) ? sclk1 : (sel == 2) ? sclk2 : sclk0;
    assign mon_sdi  = (sel == 1) ? sdi1  : (sel == 2) ? sdi2  : sdi0;

    dac_spi_multich u_dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .start(start0), .mode(mode_r),
        .ch_sel(ch_r), .data(data_r[47:0]),
        .busy(busy0), .done(done0), .sync(sync0), .sclk(sclk0), .sdi(sdi0)
    );

    dac_spi_multich #(.CLK_DIV(1), .N_CH(2), .DATA_W(14)) u_dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .start(start1), .mode(mode_r),
        .ch_sel(ch_r[0]), .data(data_r[27:0]),
        .busy(busy1), .done(done1), .sync(sync1), .sclk(sclk1), .sdi(sdi1)
    );

    dac_spi_multich #(.N_CH(3)) u_dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .start(start2), .mode(mode_r),
        .ch_sel(ch_r), .data(data_r[35:0]),
        .busy(busy2), .done(done2), .sync(sync2), .sclk(sclk2), .sdi(sdi2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observation results of one transfer.
    logic [31:0] frm[8];
    int          low[8];
    int          frm_n, busy_cyc, done_cnt, done_at, falls, min_gap;
    logic        finished;

    task automatic kick();
        @(negedge clk_in);
        start_r = 1'b1;
        @(negedge clk_in);
        start_r = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge; k counts cycles from there.
    task automatic observe(input int budget, input int poke_at);
        logic        prev_sync, prev_sclk;
        logic [31:0] sh;
        int          cur_low, cur_gap;
        prev_sync = 1'b1; prev_sclk = 1'b1; sh = '0; cur_low = 0; cur_gap = 0;
        frm_n = 0; busy_cyc = 0; done_cnt = 0; done_at = -1; falls = 0;
        min_gap = 1000000; finished = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk_in);
            if (mon_busy) busy_cyc++;
            if (mon_done) begin
                done_cnt++;
                done_at = k;
            end
            if (!mon_sync) begin
                cur_low++;
                if (prev_sclk && !mon_sclk) begin
                    sh = {sh[30:0], mon_sdi};
                    falls++;
                end
                if (prev_sync && frm_n > 0 && cur_gap < min_gap) min_gap = cur_gap;
            end
            if (mon_sync && !prev_sync) begin
                if (frm_n < 8) begin
                    frm[frm_n] = sh;
                    low[frm_n] = cur_low;
                end
                frm_n++;
                sh = '0; cur_low = 0; cur_gap = 0;
            end
            if (mon_sync && frm_n > 0 && mon_busy) cur_gap++;
            prev_sync = mon_sync;
            prev_sclk = mon_sclk;
            if (k == poke_at) begin
                start_r = 1'b1;
                data_r  = '0;
            end
            if (k == poke_at + 1) start_r = 1'b0;
            if (!mon_busy) begin
                finished = 1'b1;
                break;
            end
        end
    endtask

    typedef struct packed {
        logic             mode;
        logic [1:0]       ch;
        logic [47:0]      data;
        int               nfrm;
        logic [3:0][15:0] frames;
        int               busy;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic [1:0] c, input logic [47:0] d,
                                input int n, input logic [15:0] f0, input logic [15:0] f1,
                                input logic [15:0] f2, input logic [15:0] f3, input int b);
        vec_t v;
        v.mode = m; v.ch = c; v.data = d; v.nfrm = n;
        v.frames[0] = f0; v.frames[1] = f1; v.frames[2] = f2; v.frames[3] = f3;
        v.busy = b;
        return v;
    endfunction

    task automatic run_vec(input string tag, input vec_t v, input int poke_at);
        logic saw;
        mode_r = v.mode;
        ch_r   = v.ch;
        data_r = 64'(v.data);
        kick();
        observe(v.busy + 40, poke_at);
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_nfrm"}, frm_n, v.nfrm);
        for (int i = 0; i < v.nfrm && i < frm_n; i++) begin
            check($sformatf("%s_frame%0d", tag, i), frm[i], 32'(v.frames[i]));
            check($sformatf("%s_synclow%0d", tag, i), low[i], 68);
        end
        check({tag, "_falls"}, falls, 16 * v.nfrm);
        check({tag, "_busy"}, busy_cyc, v.busy);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, v.busy);
        if (v.nfrm > 1) check({tag, "_gap_ge4"}, 32'(min_gap >= 4), 32'd1);
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk_in);
            if (mon_busy || !mon_sync || mon_done) saw = 1'b1;
        end
        check({tag, "_idle_after"}, 32'(saw), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic saw;
        int   fc;
        logic prev;

        vecs[0] = mk(1'b0, 2'd2, 48'h000_ABC_000_000, 1, 16'h6ABC, 16'h0, 16'h0, 16'h0, 72);
        vecs[1] = mk(1'b0, 2'd0, 48'hFFF_FFF_FFF_000, 1, 16'h4000, 16'h0, 16'h0, 16'h0, 72);
        vecs[2] = mk(1'b0, 2'd3, 48'hFFF_000_000_000, 1, 16'h7FFF, 16'h0, 16'h0, 16'h0, 72);
        vecs[3] = mk(1'b0, 2'd1, 48'h000_000_555_000, 1, 16'h5555, 16'h0, 16'h0, 16'h0, 72);
        vecs[4] = mk(1'b1, 2'd2, 48'hFFF_789_456_123, 4, 16'h0123, 16'h1456, 16'h2789, 16'h7FFF, 288);
        vecs[5] = mk(1'b1, 2'd0, 48'hA5A_A5A_A5A_A5A, 4, 16'h0A5A, 16'h1A5A, 16'h2A5A, 16'h7A5A, 288);

        rst_n = 1'b0; start_r = 1'b0; mode_r = 1'b0; ch_r = '0; data_r = '0; sel = 0;

        // Reset and quiet idle.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_sync", 32'(sync0), 32'd1);
        check("rst_sclk", 32'(sclk0), 32'd1);
        check("rst_sdi",  32'(sdi0),  32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk_in);
            if (busy0 || !sync0 || !sclk0 || done0) saw = 1'b1;
        end
        check("idle_no_activity", 32'(saw), 32'd0);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

        // Start plus data wipe mid-scan: snapshot must be transmitted, no retrigger.
        run_vec("busy_start", vecs[4], 100);
        // Start coinciding with done is dropped.
        run_vec("done_start", vecs[0], 72);

        // Reset mid-frame after bit 7.
        mode_r = 1'b0; ch_r = 2'd2; data_r = 64'(vecs[0].data);
        kick();
        fc = 0; prev = 1'b1;
        for (int k = 0; k < 200 && fc < 8; k++) begin
            @(negedge clk_in);
            if (prev && !sclk0) fc++;
            prev = sclk0;
        end
        check("abort_reached_bit7", fc, 8);
        rst_n = 1'b0;
        @(negedge clk_in);
        check("abort_sync", 32'(sync0), 32'd1);
        check("abort_sclk", 32'(sclk0), 32'd1);
        check("abort_sdi",  32'(sdi0),  32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (80) begin
            @(negedge clk_in);
            if (done0 || busy0) saw = 1'b1;
        end
        check("abort_no_done", 32'(saw), 32'd0);
        run_vec("after_abort", vecs[0], 0);

        // CLK_DIV=1, N_CH=2, DATA_W=14: 17-bit frames, 36-cycle sync low.
        sel = 1;
        mode_r = 1'b0; ch_r = 2'd1; data_r = 64'(14'h2ABC) << 14;
        kick();
        observe(100, 0);
        check("sw1_finished", 32'(finished), 32'd1);
        check("sw1_nfrm", frm_n, 1);
        check("sw1_frame", frm[0], 32'h0_EABC);
        check("sw1_synclow", low[0], 36);
        check("sw1_falls", falls, 17);
        check("sw1_busy", busy_cyc, 40);
        check("sw1_done_at", done_at, 40);
        repeat (5) @(negedge clk_in);
        mode_r = 1'b1; ch_r = 2'd0; data_r = (64'(14'h3FFF) << 14) | 64'(14'h1234);
        kick();
        observe(150, 0);
        check("sw2_nfrm", frm_n, 2);
        check("sw2_frame0", frm[0], 32'h0_1234);
        check("sw2_frame1", frm[1], 32'h0_FFFF);
        check("sw2_synclow1", low[1], 36);
        check("sw2_falls", falls, 34);
        check("sw2_busy", busy_cyc, 80);
        check("sw2_done_cnt", done_cnt, 1);
        check("sw2_gap", min_gap, 4);

        // N_CH=3: ch_sel=3 is out of range and ignored; ch_sel=2 works.
        sel = 2;
        repeat (5) @(negedge clk_in);
        mode_r = 1'b0; ch_r = 2'd3; data_r = 64'h321 << 24;
        kick();
        observe(10, 0);
        check("oor_busy", busy_cyc, 0);
        check("oor_nfrm", frm_n, 0);
        check("oor_sync", 32'(sync2), 32'd1);
        run_vec("nch3_ch2", mk(1'b0, 2'd2, 48'h000_321_000_000, 1, 16'h6321, 16'h0, 16'h0, 16'h0, 72), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
